dna_reader: RTL and testbench



---
 rtl/dna_pkg.sv | 25 ++
 rtl/dna_prim_wrap.sv | 50 +++++
 rtl/dna_reader.sv | 176 +++++++++++++++++
 tb/tb_dna_reader.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dna_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dna_pkg
// Description : Shared types, widths and helpers for the device-DNA reader.
// Revision    : 1.0 - initial release
// ============================================================================
package dna_pkg;

    localparam int DNA_W_7S = 57;
    localparam int DNA_W_US = 96;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } dna_state_t;

    // Bit counter must reach DNA_WIDTH itself (the final sample-only bit-cycle).
    function automatic int dna_cnt_bw(input int width);
        return $clog2(width + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dna_prim_wrap.sv
`default_nettype none
// ============================================================================
// Module      : dna_prim_wrap
// Description : DNA primitive selected by ID width (DNA_PORT / DNA_PORTE2).
// Revision    : 1.0 - initial release
// ============================================================================
module dna_prim_wrap
    import dna_pkg::*;
#(
    parameter int                   DNA_WIDTH     = DNA_W_7S,
    parameter logic [DNA_WIDTH-1:0] SIM_DNA_VALUE = '0
) (
    input  logic clk,
    input  logic read,
    input  logic shift,
    output logic dout
);

    localparam logic c_DIN = 1'b0;

    // READ loads the ID, SHIFT moves it toward DOUT, MSB first; DIN is tied low.
    generate
        if (DNA_WIDTH == DNA_W_7S) begin : g_dna_port
            logic [DNA_W_7S-1:0] r_sr;
            always_ff @(posedge clk) begin
                if (read) begin
                    r_sr <= SIM_DNA_VALUE;
                end else if (shift) begin
                    r_sr <= {r_sr[DNA_W_7S-2:0], c_DIN};
                end
            end
            assign dout = r_sr[DNA_W_7S-1];
        end else if (DNA_WIDTH == DNA_W_US) begin : g_dna_porte2
            logic [DNA_W_US-1:0] r_sr;
            always_ff @(posedge clk) begin
                if (read) begin
                    r_sr <= SIM_DNA_VALUE;
                end else if (shift) begin
                    r_sr <= {r_sr[DNA_W_US-2:0], c_DIN};
                end
            end
            assign dout = r_sr[DNA_W_US-1];
        end else begin : g_bad_width
            $error("dna_prim_wrap: DNA_WIDTH must be 57 or 96");
            assign dout = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/dna_reader.sv
`default_nettype none
// ============================================================================
// Module      : dna_reader
// Description : Reads the factory DNA through a divided DNA clock, with
//               auto/on-demand reads and a masked licence-ID compare.
// Revision    : 1.0 - initial release
// ============================================================================
module dna_reader
    import dna_pkg::*;
#(
    parameter int                   DNA_WIDTH     = DNA_W_7S,
    parameter int                   CLK_DIV       = 2,
    parameter bit                   AUTO_RD       = 1'b1,
    parameter logic [DNA_WIDTH-1:0] EXPECT_ID     = '0,
    parameter logic [DNA_WIDTH-1:0] EXPECT_MASK   = '0,
    parameter logic [DNA_WIDTH-1:0] SIM_DNA_VALUE = DNA_WIDTH'(57'h1dc_ba98_7654_3210)
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 rd_req,
    output logic                 dna_busy,
    output logic                 dna_vld,
    output logic                 dna_rdy,
    output logic [DNA_WIDTH-1:0] dna_id,
    output logic                 id_match
);

    localparam int                 c_BIT_W      = dna_cnt_bw(DNA_WIDTH);
    localparam int                 c_DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_BIT_W-1:0] c_LAST_BIT   = c_BIT_W'(DNA_WIDTH);
    localparam logic [c_BIT_W-1:0] c_LAST_SHIFT = c_BIT_W'(DNA_WIDTH - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_MAX    = c_DIV_W'(CLK_DIV - 1);

    generate
        if (CLK_DIV < 1) begin : g_bad_div
            $error("dna_reader: CLK_DIV must be >= 1");
        end
    endgenerate

    logic [1:0]           r_rst_sync;
    logic                 w_rst;
    dna_state_t           r_state;
    dna_state_t           w_state_nxt;
    logic                 w_start;
    logic                 r_auto_pend;
    logic                 r_dna_clk;
    logic                 r_read;
    logic                 r_shift;
    logic [c_DIV_W-1:0]   r_div;
    logic [c_BIT_W-1:0]   r_bit;
    logic [DNA_WIDTH-1:0] r_cap;
    logic                 w_dout;
    logic                 w_active;
    logic                 w_tick;
    logic                 w_rise;
    logic                 w_fall;
    logic                 w_last_bit;
    logic                 w_cap_match;
    logic                 r_vld;
    logic                 r_rdy;
    logic [DNA_WIDTH-1:0] r_id;
    logic                 r_match;

    // Reset asserts asynchronously but is released on a clock edge.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_rst_sync <= 2'b11;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b0};
        end
    end
    assign w_rst = r_rst_sync[1];

    assign w_active   = (r_state == LOAD) || (r_state == SHIFT);
    assign w_tick     = w_active && (r_div == c_DIV_MAX);
    assign w_rise     = w_tick && !r_dna_clk;
    assign w_fall     = w_tick && r_dna_clk;
    assign w_last_bit = (r_bit == c_LAST_BIT);

    always_ff @(posedge sys_clk or posedge w_rst) begin
        if (w_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_auto_pend || rd_req) begin
                    w_state_nxt = LOAD;
                    w_start     = 1'b1;
                end
            end
            LOAD:    if (w_fall) w_state_nxt = SHIFT;
            SHIFT:   if (w_fall && w_last_bit) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // READ/SHIFT only move on the falling DNA-clock edge for a full half-period of setup.
    always_ff @(posedge sys_clk or posedge w_rst) begin
        if (w_rst) begin
            r_auto_pend <= AUTO_RD;
            r_dna_clk   <= 1'b0;
            r_read      <= 1'b0;
            r_shift     <= 1'b0;
            r_div       <= '0;
            r_bit       <= '0;
            r_cap       <= '0;
        end else if (w_start) begin
            r_auto_pend <= 1'b0;
            r_dna_clk   <= 1'b0;
            r_read      <= 1'b1;
            r_shift     <= 1'b0;
            r_div       <= '0;
            r_bit       <= '0;
        end else if (w_tick) begin
            r_div     <= '0;
            r_dna_clk <= ~r_dna_clk;
            if (w_rise && (r_bit != '0)) begin
                r_cap <= {r_cap[DNA_WIDTH-2:0], w_dout};
            end
            if (w_fall && !w_last_bit) begin
                r_bit   <= r_bit + c_BIT_W'(1);
                r_read  <= 1'b0;
                r_shift <= (r_bit < c_LAST_SHIFT);
            end
        end else if (w_active) begin
            r_div <= r_div + c_DIV_W'(1);
        end
    end

    assign w_cap_match = ((r_cap & EXPECT_MASK) == (EXPECT_ID & EXPECT_MASK)) &&
                         (EXPECT_MASK != '0);

    always_ff @(posedge sys_clk or posedge w_rst) begin
        if (w_rst) begin
            r_vld   <= 1'b0;
            r_rdy   <= 1'b0;
            r_id    <= '0;
            r_match <= 1'b0;
        end else begin
            r_vld <= (r_state == DONE);
            if (r_state == DONE) begin
                r_rdy   <= 1'b1;
                r_id    <= r_cap;
                r_match <= w_cap_match;
            end else if (w_start) begin
                r_rdy <= 1'b0;
            end
        end
    end

    dna_prim_wrap #(
        .DNA_WIDTH     (DNA_WIDTH),
        .SIM_DNA_VALUE (SIM_DNA_VALUE)
    ) u_dna_prim (
        .clk   (r_dna_clk),
        .read  (r_read),
        .shift (r_shift),
        .dout  (w_dout)
    );

    assign dna_busy = (r_state != IDLE);
    assign dna_vld  = r_vld;
    assign dna_rdy  = r_rdy;
    assign dna_id   = r_id;
    assign id_match = r_match;

endmodule
`default_nettype wire

// File: tb/tb_dna_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_dna_reader
// Description : Self-checking bench for dna_reader against a timing/ID model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dna_reader;

    localparam int          c_W_A       = 57;
    localparam int          c_DIV_A     = 2;
    localparam int          c_W_B       = 96;
    localparam int          c_DIV_B     = 1;
    localparam int          c_REL_EDGES = 3;
    localparam int          c_WIN       = 720;
    localparam logic [56:0] c_SIM_A     = 57'h1dc_ba98_7654_3210;
    localparam logic [56:0] c_ONES_A    = {57{1'b1}};
    localparam logic [56:0] c_EXP_C     = 57'h1dc_ba98_7654_3211;
    localparam logic [95:0] c_SIM_B     = 96'h0123_4567_89ab_cdef_fedc_ba98;
    localparam logic [95:0] c_MASK_B    = 96'h0000_0000_0000_0000_ffff_0000;
    localparam logic [95:0] c_EXP_B     = 96'h0000_0000_0000_0000_fedc_0000;

    logic        sys_clk;
    logic        sys_rst;
    logic        rd_req_a;
    logic        rd_req_b;
    logic        busy_a, vld_a, rdy_a, match_a;
    logic        busy_c, vld_c, rdy_c, match_c;
    logic        busy_d, vld_d, rdy_d, match_d;
    logic        busy_b, vld_b, rdy_b, match_b;
    logic [56:0] id_a, id_c, id_d;
    logic [95:0] id_b;

    int checks = 0;
    int errors = 0;

    dna_reader #(.DNA_WIDTH(c_W_A), .CLK_DIV(c_DIV_A), .AUTO_RD(1'b1), .EXPECT_ID(c_SIM_A),
                 .EXPECT_MASK(c_ONES_A), .SIM_DNA_VALUE(c_SIM_A)) dut_a (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .rd_req(rd_req_a), .dna_busy(busy_a),
        .dna_vld(vld_a), .dna_rdy(rdy_a), .dna_id(id_a), .id_match(match_a));

    dna_reader #(.DNA_WIDTH(c_W_A), .CLK_DIV(c_DIV_A), .AUTO_RD(1'b1), .EXPECT_ID(c_EXP_C),
                 .EXPECT_MASK(c_ONES_A), .SIM_DNA_VALUE(c_SIM_A)) dut_c (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .rd_req(rd_req_a), .dna_busy(busy_c),
        .dna_vld(vld_c), .dna_rdy(rdy_c), .dna_id(id_c), .id_match(match_c));

    dna_reader #(.DNA_WIDTH(c_W_A), .CLK_DIV(c_DIV_A), .AUTO_RD(1'b1), .EXPECT_ID(c_SIM_A),
                 .EXPECT_MASK(57'd0), .SIM_DNA_VALUE(c_SIM_A)) dut_d (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .rd_req(rd_req_a), .dna_busy(busy_d),
        .dna_vld(vld_d), .dna_rdy(rdy_d), .dna_id(id_d), .id_match(match_d));

    dna_reader #(.DNA_WIDTH(c_W_B), .CLK_DIV(c_DIV_B), .AUTO_RD(1'b0), .EXPECT_ID(c_EXP_B),
                 .EXPECT_MASK(c_MASK_B), .SIM_DNA_VALUE(c_SIM_B)) dut_b (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .rd_req(rd_req_b), .dna_busy(busy_b),
        .dna_vld(vld_b), .dna_rdy(rdy_b), .dna_id(id_b), .id_match(match_b));

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    // A read is W+1 DNA bit-cycles of 2*DIV sys_clk cycles, plus the DONE cycle.
    function automatic int model_latency(input int w, input int div);
        return 2 * div * (w + 1) + 1;
    endfunction

    function automatic logic model_match(input logic [95:0] id, input logic [95:0] exp_id,
                                         input logic [95:0] mask);
        logic any_bit = 1'b0;
        logic all_eq  = 1'b1;
        for (int i = 0; i < 96; i++) begin
            if (mask[i]) begin
                any_bit = 1'b1;
                if (id[i] != exp_id[i]) all_eq = 1'b0;
            end
        end
        return any_bit && all_eq;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_vld_a(input int start, input int limit, output int cycles);
        cycles = start;
        while (vld_a !== 1'b1 && cycles < limit) begin
            @(negedge sys_clk);
            cycles++;
        end
    endtask

    initial begin
        int          n;
        int          k;
        int          r1;
        int          r2;
        int          rises;
        logic        prev;
        int          lat_a;
        int          lat_b;
        int          va[$];
        int          vb[$];
        logic        e_match_a, e_match_c, e_match_d, e_match_b;

        lat_a     = model_latency(c_W_A, c_DIV_A);
        lat_b     = model_latency(c_W_B, c_DIV_B);
        e_match_a = model_match({39'd0, c_SIM_A}, {39'd0, c_SIM_A}, {39'd0, c_ONES_A});
        e_match_c = model_match({39'd0, c_SIM_A}, {39'd0, c_EXP_C}, {39'd0, c_ONES_A});
        e_match_d = model_match({39'd0, c_SIM_A}, {39'd0, c_SIM_A}, 96'd0);
        e_match_b = model_match(c_SIM_B, c_EXP_B, c_MASK_B);

        sys_rst  = 1'b1;
        rd_req_a = 1'b0;
        rd_req_b = 1'b0;
        repeat (4) @(negedge sys_clk);
        check("rst_busy_a", busy_a, 0);
        check("rst_vld_a", vld_a, 0);
        check("rst_rdy_a", rdy_a, 0);
        check("rst_id_a", id_a, 0);
        check("rst_match_a", match_a, 0);
        check("rst_id_b", id_b, 0);

        // Auto read after reset release.
        sys_rst = 1'b0;
        wait_vld_a(0, c_REL_EDGES + lat_a + 50, n);
        check("t1_latency", n, c_REL_EDGES + lat_a);
        check("t1_id_a", id_a, c_SIM_A);
        check("t1_rdy_a", rdy_a, 1);
        check("t1_busy_a", busy_a, 0);
        check("t1_match_a", match_a, e_match_a);
        check("t1_vld_c", vld_c, 1);
        check("t1_id_c", id_c, c_SIM_A);
        check("t4_match_c", match_c, e_match_c);
        check("t4_match_d", match_d, e_match_d);
        @(negedge sys_clk);
        check("t1_vld_pulse", vld_a, 0);
        check("t1_rdy_hold", rdy_a, 1);
        check("t2_no_auto_rdy_b", rdy_b, 0);
        check("t2_no_auto_busy_b", busy_b, 0);

        // On-demand 96-bit read with DIV=1.
        repeat ($urandom_range(1, 15)) @(negedge sys_clk);
        rd_req_b = 1'b1;
        @(negedge sys_clk);
        rd_req_b = 1'b0;
        n     = 1;
        prev  = dut_b.r_dna_clk;
        rises = 0;
        r1    = 0;
        r2    = 0;
        while (vld_b !== 1'b1 && n < lat_b + 50) begin
            @(negedge sys_clk);
            n++;
            if (dut_b.r_dna_clk && !prev) begin
                rises++;
                if (rises == 1) r1 = n;
                if (rises == 2) r2 = n;
            end
            prev = dut_b.r_dna_clk;
        end
        check("t2_latency", n, lat_b + 1);
        check("t2_id_b", id_b, c_SIM_B);
        check("t2_match_b", match_b, e_match_b);
        check("t2_rdy_b", rdy_b, 1);
        check("t2_dclk_period", r2 - r1, 2 * c_DIV_B);
        check("t2_dclk_rises", rises, c_W_B + 1);

        // Re-read with an ignored mid-read request.
        repeat ($urandom_range(1, 15)) @(negedge sys_clk);
        rd_req_a = 1'b1;
        @(negedge sys_clk);
        rd_req_a = 1'b0;
        check("t3_rdy_low", rdy_a, 0);
        check("t3_busy", busy_a, 1);
        check("t3_id_held", id_a, c_SIM_A);
        k = $urandom_range(20, 200);
        repeat (k) @(negedge sys_clk);
        rd_req_a = 1'b1;
        @(negedge sys_clk);
        rd_req_a = 1'b0;
        check("t3_rdy_mid", rdy_a, 0);
        check("t3_id_mid", id_a, c_SIM_A);
        wait_vld_a(k + 2, lat_a + 50, n);
        check("t3_latency", n, lat_a + 1);
        check("t3_id_a", id_a, c_SIM_A);
        k = 0;
        for (int i = 0; i < lat_a + 20; i++) begin
            @(negedge sys_clk);
            if (vld_a === 1'b1) k++;
        end
        check("t3_extra_vld", k, 0);
        check("t3_idle", busy_a, 0);

        // Reset around sample 30, then the automatic re-read.
        repeat ($urandom_range(1, 15)) @(negedge sys_clk);
        rd_req_a = 1'b1;
        @(negedge sys_clk);
        rd_req_a = 1'b0;
        n = 1;
        k = 2 * c_DIV_A * 30 + c_DIV_A + $urandom_range(0, 3);
        while (n < k) begin
            @(negedge sys_clk);
            n++;
        end
        check("t5_busy_pre", busy_a, 1);
        sys_rst = 1'b1;
        #1;
        check("t5_busy", busy_a, 0);
        check("t5_vld", vld_a, 0);
        check("t5_rdy", rdy_a, 0);
        check("t5_id", id_a, 0);
        check("t5_match", match_a, 0);
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        wait_vld_a(0, c_REL_EDGES + lat_a + 50, n);
        check("t5_latency", n, c_REL_EDGES + lat_a);
        check("t5_id_a", id_a, c_SIM_A);
        check("t5_match_a", match_a, e_match_a);

        // Request held high: back-to-back reads.
        repeat ($urandom_range(1, 15)) @(negedge sys_clk);
        rd_req_a = 1'b1;
        rd_req_b = 1'b1;
        for (int i = 1; i <= c_WIN; i++) begin
            @(negedge sys_clk);
            if (vld_a === 1'b1) va.push_back(i);
            if (vld_b === 1'b1) vb.push_back(i);
        end
        rd_req_a = 1'b0;
        rd_req_b = 1'b0;
        check("t6_cnt_a", va.size(), c_WIN / (lat_a + 1));
        check("t6_cnt_b", vb.size(), c_WIN / (lat_b + 1));
        for (int i = 1; i < va.size(); i++) check("t6_space_a", va[i] - va[i-1], lat_a + 1);
        for (int i = 1; i < vb.size(); i++) check("t6_space_b", vb[i] - vb[i-1], lat_b + 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
